stream_demux: RTL
=================

// Module: stream_demux
//
// PURPOSE
//   Inverse of the mux primitive: routes one valid/ready input stream to one of
//   N_OUT output streams, selected per beat by up_sel.
//   Each output has a 2-entry buffer, so the block runs at full throughput and
//   one stalled output never blocks beats addressed to the others.
//   Sits between a single producer and N_OUT independent consumers.
//
// PARAMETERS
//   N_OUT   4   number of output channels (>= 2)
//   W       8   data width in bits
//   SEL_W   $clog2(N_OUT)   select width; derived localparam, not overridable
//
// PORTS
//   clk          in   1            clock; all state updates on rising edge
//   rst_n        in   1            synchronous, active-low reset
//   up_valid     in   1            input beat present
//   up_ready     out  1            input beat accepted when up_valid && up_ready
//   up_sel       in   SEL_W        destination channel of current beat
//   up_data      in   W            input payload
//   dn_valid     out  N_OUT        per-channel output beat present
//   dn_ready     in   N_OUT        per-channel consumer ready
//   dn_data      out  N_OUT*W      channel i payload at [i*W +: W]
//   bad_sel_cnt  out  16           count of beats dropped for up_sel >= N_OUT
//
// BEHAVIOUR
//   - Reset (rst_n sampled low at a clock edge):
//     - all buffers EMPTY; dn_valid = 0, dn_data = 0, bad_sel_cnt = 0.
//     - up_ready = 0 while rst_n is low.
//     - Reset mid-transfer discards all buffered beats and does not count them.
//   - Per-channel buffer FSM, states EMPTY / ONE / TWO:
//     - push = accepted beat with up_sel == i; pop = dn_valid[i] && dn_ready[i].
//     - EMPTY --push--> ONE.
//     - ONE --push & !pop--> TWO; ONE --!push & pop--> EMPTY; ONE --push & pop--> ONE.
//     - TWO --pop--> ONE. No push is possible in TWO.
//   - Output side:
//     - dn_valid[i] = (state != EMPTY); dn_data slice = head entry.
//     - dn_data slice holds its last value when EMPTY.
//     - dn_valid and dn_data are driven from registers, with no combinational
//       path from the up_* ports.
//   - Input side:
//     - up_ready = rst_n && (up_sel >= N_OUT || state[up_sel] != TWO).
//     - up_ready depends only on registered state and up_sel, never on dn_ready,
//       so there is no dn_ready -> up_ready combinational path.
//     - Consequence: a full channel whose consumer pops this cycle still stalls
//       the input for that cycle.
//   - Latency: a beat accepted at edge k appears on dn_* right after edge k.
//     One-cycle latency; back-to-back beats to a ready channel sustain 1 beat/clk.
//   - Ordering: per-channel FIFO order is preserved. Beats to different channels
//     are unordered relative to each other.
//   - Bad select (up_sel >= N_OUT, only possible when N_OUT is not a power of 2):
//     - the beat is accepted (up_ready = 1) and dropped.
//     - bad_sel_cnt increments by 1 and saturates at 16'hFFFF.
//   - Protocol rules:
//     - Once up_valid is high, up_sel and up_data must be held stable until
//       the beat is accepted. The block does not check this.
//     - The block never drops dn_valid[i] before the beat on channel i is
//       popped, and dn_data[i*W +: W] is stable while dn_valid[i] is high.
//
// STRUCTURE
//   - Package stream_demux_pkg holds:
//     - typedef enum logic [1:0] {BUF_EMPTY, BUF_ONE, BUF_TWO} buf_state_t;
//     - localparam BAD_SEL_CNT_W = 16.
//   - Sub-module demux_out_buffer (params W), instantiated N_OUT times in a
//     generate loop:
//     - 2-entry FIFO with push/pop/full/valid/head.
//     - holds the buf_state_t FSM and a head/tail pointer pair.
//   - The top level holds only the select decode, the up_ready mux and the
//     saturating counter.
//
// TESTING
//   - Reset, N_OUT=4:
//     - hold rst_n=0 for 3 clks with up_valid=1 -> up_ready=0, dn_valid=4'b0000,
//       bad_sel_cnt=0.
//     - after release, up_ready=1.
//   - Streaming:
//     - send 0x11,0x22,0x33 to sel=2 on consecutive clks with dn_ready=4'b1111
//       -> dn_valid[2] high 1 clk later; 0x11,0x22,0x33 appear in order.
//     - up_ready stays 1 throughout.
//   - Backpressure:
//     - dn_ready[1]=0, send 0xA0,0xA1,0xA2 to sel=1 -> first two accepted,
//       then up_ready=0 on the third.
//     - meanwhile sel=3 beat 0x5C is accepted at once.
//     - raise dn_ready[1] -> 0xA0,0xA1,0xA2 come out in order, no loss.
//   - Full channel, pop and push request in the same cycle:
//     - channel 0 in TWO with dn_ready[0]=1, new beat to sel=0 -> the beat is
//       stalled exactly 1 clk, then accepted.
//   - Bad select, N_OUT=3:
//     - send 5 beats with up_sel=3 -> all accepted, no dn_valid asserted,
//       bad_sel_cnt=5.
//     - force the counter to 16'hFFFE and send 3 more -> it reads 16'hFFFF.
//   - Reset mid-operation:
//     - channels 0 and 2 in TWO, pulse rst_n=0 for 1 clk -> all dn_valid=0 next
//       clk; no stale beats emerge afterwards.

Source files
------------

// File: rtl/stream_demux_pkg.sv
// Shared types and constants for the stream demultiplexer.
//   buf_state_t    : occupancy state of one per-channel output buffer
//   BAD_SEL_CNT_W  : width of the dropped-beat (bad select) counter
package stream_demux_pkg;

  typedef enum logic [1:0] {
    BUF_EMPTY,
    BUF_ONE,
    BUF_TWO
  } buf_state_t;

  localparam int BAD_SEL_CNT_W = 16;

endpackage

// File: rtl/demux_out_buffer.sv
// Two-entry FIFO sitting in front of one demux output channel.
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   i_push       : write i_data (ignored when full)
//   i_ready      : consumer ready; a pop happens when i_ready && o_valid
//   i_data       : payload to write
//   o_valid      : buffer holds at least one beat
//   o_full       : buffer holds two beats
//   o_head       : oldest beat, registered; holds last value when empty
//
// state     | meaning
// ----------+------------------------------------
// BUF_EMPTY | no beat stored, o_valid low
// BUF_ONE   | one beat stored, shown on o_head
// BUF_TWO   | two beats stored, input must stall
module demux_out_buffer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic         i_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  output logic         o_full,
  output logic [W-1:0] o_head
);
  import stream_demux_pkg::*;

  buf_state_t   r_state;
  logic [W-1:0] r_mem [2];
  logic         r_head_ptr;
  logic         r_tail_ptr;
  logic [W-1:0] r_head;
  logic         w_push;
  logic         w_pop;

  assign w_push  = i_push && (r_state != BUF_TWO);
  assign w_pop   = i_ready && (r_state != BUF_EMPTY);
  assign o_valid = (r_state != BUF_EMPTY);
  assign o_full  = (r_state == BUF_TWO);
  assign o_head  = r_head;

  // r_head is a registered copy of the head entry so the output never
  // glitches through the pointer mux and keeps its value once drained.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= BUF_EMPTY;
      r_head_ptr <= 1'b0;
      r_tail_ptr <= 1'b0;
      r_mem[0]   <= '0;
      r_mem[1]   <= '0;
      r_head     <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_tail_ptr] <= i_data;
        r_tail_ptr        <= ~r_tail_ptr;
      end
      if (w_pop) begin
        r_head_ptr <= ~r_head_ptr;
      end
      case (r_state)
        BUF_EMPTY: begin
          if (w_push) begin
            r_state <= BUF_ONE;
            r_head  <= i_data;
          end
        end
        BUF_ONE: begin
          if (w_push && !w_pop) begin
            r_state <= BUF_TWO;
          end else if (w_push && w_pop) begin
            r_head <= i_data;
          end else if (w_pop) begin
            r_state <= BUF_EMPTY;
          end
        end
        BUF_TWO: begin
          if (w_pop) begin
            r_state <= BUF_ONE;
            r_head  <= r_mem[~r_head_ptr];
          end
        end
        default: r_state <= BUF_EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/stream_demux.sv
// Routes one valid/ready stream to one of N_OUT output streams chosen per
// beat by up_sel. Each output has its own two-entry buffer so a stalled
// consumer only blocks beats addressed to it.
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   up_valid/up_ready/up_sel/up_data : producer side
//   dn_valid/dn_ready/dn_data        : per-channel consumer side,
//                                      channel i data at [i*W +: W]
//   bad_sel_cnt  : saturating count of beats dropped for up_sel >= N_OUT
module stream_demux #(
  parameter  int N_OUT = 4,
  parameter  int W     = 8,
  localparam int SEL_W = $clog2(N_OUT)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               up_valid,
  output logic               up_ready,
  input  logic [SEL_W-1:0]   up_sel,
  input  logic [W-1:0]       up_data,
  output logic [N_OUT-1:0]   dn_valid,
  input  logic [N_OUT-1:0]   dn_ready,
  output logic [N_OUT*W-1:0] dn_data,
  output logic [15:0]        bad_sel_cnt
);
  import stream_demux_pkg::*;

  localparam logic [SEL_W:0] N_OUT_L = N_OUT[SEL_W:0];

  logic [N_OUT-1:0]         w_full;
  logic [(1<<SEL_W)-1:0]    w_full_pad;
  logic                     w_sel_ok;
  logic                     w_accept;
  logic [BAD_SEL_CNT_W-1:0] r_bad_sel_cnt;

  assign w_sel_ok = ({1'b0, up_sel} < N_OUT_L);

  // Pad the full vector to the whole select range so an out-of-range
  // select indexes a defined (never-full) bit.
  always_comb begin
    w_full_pad             = '0;
    w_full_pad[N_OUT-1:0]  = w_full;
  end

  // Depends only on registered state and up_sel: no dn_ready -> up_ready path.
  assign up_ready = rst_n && (!w_sel_ok || !w_full_pad[up_sel]);
  assign w_accept = up_valid && up_ready;

  for (genvar i = 0; i < N_OUT; i++) begin : g_ch
    logic w_push;
    assign w_push = w_accept && (up_sel == SEL_W'(i));

    demux_out_buffer #(.W(W)) u_buf (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_ready (dn_ready[i]),
      .i_data  (up_data),
      .o_valid (dn_valid[i]),
      .o_full  (w_full[i]),
      .o_head  (dn_data[i*W +: W])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bad_sel_cnt <= '0;
    end else if (w_accept && !w_sel_ok && (r_bad_sel_cnt != '1)) begin
      r_bad_sel_cnt <= r_bad_sel_cnt + 1'b1;
    end
  end

  assign bad_sel_cnt = r_bad_sel_cnt;

endmodule
